bp_fe_resp_stream_buffer: RTL and testbench



---
 rtl/bp_fe_resp_stream_buffer.sv | 179 +++++++++++++++++
 tb/tb_bp_fe_resp_stream_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_resp_stream_buffer.sv
// Multi-channel response buffer: per-channel FIFOs merged by a locked round-robin arbiter.
// Optional LFSR consumer stalls are enabled with `define BP_RESP_STREAM_RANDOM_STALL_EN.
module bp_fe_resp_stream_buffer #(
    parameter int          width_p     = 32,
    parameter int          els_p       = 16,
    parameter int          channels_p  = 2,
    parameter int          min_delay_p = 0,
    parameter int          max_delay_p = 15,
    parameter logic [15:0] seed_p      = 16'hACE1,
    localparam int ptr_w_lp  = $clog2(els_p),
    localparam int cnt_w_lp  = ptr_w_lp + 1,
    localparam int chan_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [channels_p-1:0]            v_i,
    input  logic [channels_p*width_p-1:0]    data_i,
    output logic [channels_p-1:0]            ready_o,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    output logic [chan_w_lp-1:0]             chan_o,
    input  logic                             ready_and_i,
    input  logic                             clear_i,
    output logic [channels_p*cnt_w_lp-1:0]   hwm_o,
    output logic [channels_p-1:0]            overflow_o
);

    if (els_p < 2 || (1 << ptr_w_lp) != els_p) begin : g_bad_els
        $error("els_p must be a power of two and at least 2");
    end
    if (channels_p < 1 || channels_p > 4) begin : g_bad_chan
        $error("channels_p must be in 1..4");
    end
    if (max_delay_p < min_delay_p || min_delay_p < 0) begin : g_bad_delay
        $error("max_delay_p must be >= min_delay_p >= 0");
    end
    if (seed_p == 16'h0) begin : g_bad_seed
        $error("seed_p must be nonzero");
    end

    logic [width_p-1:0]   mem_r   [channels_p][els_p];
    logic [ptr_w_lp-1:0]  rptr_r  [channels_p];
    logic [ptr_w_lp-1:0]  wptr_r  [channels_p];
    logic [cnt_w_lp-1:0]  count_r [channels_p];
    logic [cnt_w_lp-1:0]  count_n [channels_p];
    logic [cnt_w_lp-1:0]  hwm_r   [channels_p];

    logic [channels_p-1:0] enq, deq, nonempty, overflow_r;
    logic [chan_w_lp-1:0]  rr_r, grant_r, grant_c, grant;
    logic                  lock_r, stall, xfer;

    // ready_o is a pure function of occupancy and reset; a full FIFO never accepts,
    // even while it is being popped.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        nonempty = '0;
        ready_o  = '0;
        enq      = '0;
        for (int c = 0; c < channels_p; c++) begin
            nonempty[c] = (count_r[c] != '0);
            ready_o[c]  = reset_n_i & (count_r[c] != cnt_w_lp'(els_p));
            enq[c]      = v_i[c] & ready_o[c];
        end
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        grant_c = rr_r;
        for (int i = 1; i <= channels_p; i++) begin
            if (!found && nonempty[(int'(rr_r) + i) % channels_p]) begin
                grant_c = chan_w_lp'((int'(rr_r) + i) % channels_p);
                found   = 1'b1;
            end
        end
    end

    // A stalled-but-valid output keeps its grant so data_o/chan_o stay stable.
    assign grant  = lock_r ? grant_r : grant_c;
    assign v_o    = ~stall & (|nonempty);
    assign xfer   = v_o & ready_and_i;
    assign data_o = v_o ? mem_r[grant][rptr_r[grant]] : '0;
    assign chan_o = v_o ? grant : '0;

    always_comb begin
        deq = '0;
        for (int c = 0; c < channels_p; c++) begin
            deq[c]     = xfer & (grant == chan_w_lp'(c));
            count_n[c] = count_r[c];
            if (enq[c] && !deq[c]) count_n[c] = count_r[c] + 1'b1;
            else if (deq[c] && !enq[c]) count_n[c] = count_r[c] - 1'b1;
        end
    end

    // NOTE: storage is not reset; only pointers and counts are, which is enough to empty the FIFOs.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < channels_p; c++) begin
            if (enq[c]) mem_r[c][wptr_r[c]] <= data_i[c*width_p +: width_p];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < channels_p; c++) begin
                rptr_r[c]  <= '0;
                wptr_r[c]  <= '0;
                count_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < channels_p; c++) begin
                if (enq[c]) wptr_r[c] <= wptr_r[c] + 1'b1;
                if (deq[c]) rptr_r[c] <= rptr_r[c] + 1'b1;
                count_r[c] <= count_n[c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r    <= chan_w_lp'(channels_p - 1);
            grant_r <= '0;
            lock_r  <= 1'b0;
        end else if (xfer) begin
            rr_r    <= grant;
            lock_r  <= 1'b0;
        end else if (v_o) begin
            grant_r <= grant;
            lock_r  <= 1'b1;
        end
    end

    // An overflow or enqueue in the same cycle as clear_i takes priority over the clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_r <= '0;
            for (int c = 0; c < channels_p; c++) hwm_r[c] <= '0;
        end else begin
            for (int c = 0; c < channels_p; c++) begin
                if (v_i[c] && !ready_o[c]) overflow_r[c] <= 1'b1;
                else if (clear_i)          overflow_r[c] <= 1'b0;

                if (enq[c] && (clear_i || count_n[c] > hwm_r[c])) hwm_r[c] <= count_n[c];
                else if (clear_i)                                 hwm_r[c] <= '0;
            end
        end
    end

    always_comb begin
        hwm_o = '0;
        for (int c = 0; c < channels_p; c++) hwm_o[c*cnt_w_lp +: cnt_w_lp] = hwm_r[c];
    end
    assign overflow_o = overflow_r;

`ifdef BP_RESP_STREAM_RANDOM_STALL_EN
    localparam int range_lp = max_delay_p - min_delay_p + 1;
    localparam int dly_w_lp = (max_delay_p > 0) ? $clog2(max_delay_p + 1) : 1;

    logic [15:0]         lfsr_r;
    logic [dly_w_lp-1:0] delay_r;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_r  <= seed_p;
            delay_r <= '0;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
            if (xfer)                 delay_r <= dly_w_lp'(min_delay_p + int'(lfsr_r) % range_lp);
            else if (delay_r != '0)   delay_r <= delay_r - 1'b1;
        end
    end

    assign stall = (delay_r != '0);
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fe_resp_stream_buffer.sv
// Directed bench for bp_fe_resp_stream_buffer: reset, fill/order, round-robin, lock/clear,
// mid-stream reset, and (with BP_RESP_STREAM_RANDOM_STALL_EN) random stall gaps.
module tb_bp_fe_resp_stream_buffer;

    localparam int W  = 32;
    localparam int E  = 16;
    localparam int C  = 2;
    localparam int CW = 5;
`ifdef BP_RESP_STREAM_RANDOM_STALL_EN
    localparam int MIN_D = 2;
    localparam int MAX_D = 5;
`else
    localparam int MIN_D = 0;
    localparam int MAX_D = 15;
`endif

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [C-1:0]    v_i;
    logic [C*W-1:0]  data_i;
    logic [C-1:0]    ready_o;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic [0:0]      chan_o;
    logic            ready_and_i;
    logic            clear_i;
    logic [C*CW-1:0] hwm_o;
    logic [C-1:0]    overflow_o;

    int n_checks = 0;
    int n_pass   = 0;
    int gaps [2][32];

    bp_fe_resp_stream_buffer #(
        .width_p(W), .els_p(E), .channels_p(C),
        .min_delay_p(MIN_D), .max_delay_p(MAX_D), .seed_p(16'hACE1)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .chan_o(chan_o),
        .ready_and_i(ready_and_i), .clear_i(clear_i), .hwm_o(hwm_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_n_i   = 1'b0;
        v_i         = '0;
        data_i      = '0;
        ready_and_i = 1'b0;
        clear_i     = 1'b0;
        repeat (3) tick();
        reset_n_i = 1'b1;
    endtask

    // Waits (bounded) for v_o with ready_and_i high, checks the head, and lets it transfer.
    task automatic pop_expect(input logic [W-1:0] exp_d, input logic exp_c,
                              input string name, output int waited);
        waited = 0;
        while (!v_o && waited < 40) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!v_o) $display("FAIL %s timeout: v_o=%b required 1", name, v_o);
        else if (data_o !== exp_d || chan_o !== exp_c)
            $display("FAIL %s: data=%h chan=%0d required data=%h chan=%0d", name, data_o, chan_o, exp_d, exp_c);
        else n_pass++;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!v_o && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (!v_o) $display("FAIL %s timeout: v_o=%b required 1", name, v_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        v_i         = 2'b11;
        data_i      = {32'h0000_0BBB, 32'h0000_0AAA};
        ready_and_i = 1'b0;
        clear_i     = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (ready_o !== 2'b00 || v_o !== 1'b0 || data_o !== '0 || chan_o !== 1'b0)
            $display("FAIL reset_outputs: ready=%b v=%b data=%h chan=%0d required 00 0 0 0", ready_o, v_o, data_o, chan_o);
        else n_pass++;
        n_checks++;
        if (hwm_o !== '0 || overflow_o !== '0)
            $display("FAIL reset_stats: hwm=%h ovf=%b required 0 0", hwm_o, overflow_o);
        else n_pass++;
        v_i = 2'b00;
        reset_n_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 2'b11) $display("FAIL reset_release_ready: ready=%b required 11", ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (v_o !== 1'b0) $display("FAIL reset_no_enqueue: v_o=%b required 0", v_o);
        else n_pass++;
    endtask

    task automatic test_fill_order();
        int w;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            v_i    = 2'b01;
            data_i = {32'h0, 32'(32'h100 + i)};
            tick();
        end
        n_checks++;
        if (ready_o !== 2'b10) $display("FAIL fill_full_ready: ready=%b required 10", ready_o);
        else n_pass++;
        data_i = {32'h0, 32'hDEAD};
        tick();
        v_i = 2'b00;
        n_checks++;
        if (overflow_o !== 2'b01) $display("FAIL fill_overflow: ovf=%b required 01", overflow_o);
        else n_pass++;
        n_checks++;
        if (hwm_o[CW-1:0] !== 5'd16) $display("FAIL fill_hwm: hwm0=%0d required 16", hwm_o[CW-1:0]);
        else n_pass++;
        ready_and_i = 1'b1;
        for (int i = 0; i < 16; i++) pop_expect(32'(32'h100 + i), 1'b0, "fill_pop", w);
        ready_and_i = 1'b0;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 2'b11)
            $display("FAIL fill_drained: v_o=%b ready=%b required 0 11", v_o, ready_o);
        else n_pass++;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (hwm_o !== '0 || overflow_o !== '0)
            $display("FAIL fill_clear: hwm=%h ovf=%b required 0 0", hwm_o, overflow_o);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int w;
        apply_reset();
        v_i = 2'b11; data_i = {32'h0000_00B0, 32'h0000_00A0}; tick();
        v_i = 2'b11; data_i = {32'h0000_00B1, 32'h0000_00A1}; tick();
        v_i = 2'b00;
        ready_and_i = 1'b1;
        pop_expect(32'hA0, 1'b0, "rr_a0", w);
        pop_expect(32'hB0, 1'b1, "rr_b0", w);
        pop_expect(32'hA1, 1'b0, "rr_a1", w);
        pop_expect(32'hB1, 1'b1, "rr_b1", w);
        ready_and_i = 1'b0;
    endtask

    task automatic test_lock_clear();
        int w;
        apply_reset();
        v_i = 2'b01; data_i = {32'h0, 32'h50}; tick();
        v_i = 2'b01; data_i = {32'h0, 32'h51}; tick();
        v_i = 2'b00;
        ready_and_i = 1'b1;
        pop_expect(32'h50, 1'b0, "lock_pre_pop", w);
        ready_and_i = 1'b0;
        wait_valid("lock_wait");
        // Channel 1 now has priority, but the held grant on channel 0 must not move.
        for (int i = 0; i < 3; i++) begin
            v_i    = 2'b10;
            data_i = {32'(32'h66 + i), 32'h0};
            tick();
            n_checks++;
            if (v_o !== 1'b1 || data_o !== 32'h51 || chan_o !== 1'b0)
                $display("FAIL lock_hold%0d: v=%b data=%h chan=%0d required 1 51 0", i, v_o, data_o, chan_o);
            else n_pass++;
        end
        v_i = 2'b00;
        n_checks++;
        if (hwm_o !== {5'd3, 5'd2}) $display("FAIL lock_hwm: hwm=%h required %h", hwm_o, {5'd3, 5'd2});
        else n_pass++;
        clear_i = 1'b1;
        v_i     = 2'b10;
        data_i  = {32'h69, 32'h0};
        tick();
        v_i = 2'b00;
        n_checks++;
        if (hwm_o !== {5'd4, 5'd0}) $display("FAIL clear_vs_enq: hwm=%h required %h", hwm_o, {5'd4, 5'd0});
        else n_pass++;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (hwm_o !== '0 || overflow_o !== '0)
            $display("FAIL clear_stats: hwm=%h ovf=%b required 0 0", hwm_o, overflow_o);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            v_i    = 2'b11;
            data_i = {32'(32'h310 + i), 32'(32'h210 + i)};
            tick();
        end
        v_i = 2'b00;
        ready_and_i = 1'b1;
        wait_valid("mid_wait");
        tick();
        ready_and_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 2'b00)
            $display("FAIL mid_reset_async: v_o=%b ready=%b required 0 00", v_o, ready_o);
        else n_pass++;
        repeat (2) tick();
        reset_n_i = 1'b1;
        #1;
        n_checks++;
        if (v_o !== 1'b0 || ready_o !== 2'b11 || hwm_o !== '0)
            $display("FAIL mid_reset_empty: v_o=%b ready=%b hwm=%h required 0 11 0", v_o, ready_o, hwm_o);
        else n_pass++;
        v_i    = 2'b10;
        data_i = {32'h77, 32'h0};
        tick();
        v_i = 2'b00;
        n_checks++;
        if (v_o !== 1'b1 || data_o !== 32'h77 || chan_o !== 1'b1)
            $display("FAIL mid_reset_next: v=%b data=%h chan=%0d required 1 77 1", v_o, data_o, chan_o);
        else n_pass++;
    endtask

`ifdef BP_RESP_STREAM_RANDOM_STALL_EN
    task automatic run_stall(input int pass);
        int w;
        logic [W-1:0] exp_d;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            v_i    = 2'b11;
            data_i = {32'(32'h300 + i), 32'(32'h200 + i)};
            tick();
        end
        v_i = 2'b00;
        ready_and_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_d = (k % 2 == 0) ? 32'(32'h200 + k / 2) : 32'(32'h300 + k / 2);
            pop_expect(exp_d, 1'(k % 2), "stall_pop", w);
            gaps[pass][k] = w;
            if (k > 0) begin
                n_checks++;
                if (w < MIN_D || w > MAX_D)
                    $display("FAIL stall_gap%0d: gap=%0d required %0d..%0d", k, w, MIN_D, MAX_D);
                else n_pass++;
            end
        end
        ready_and_i = 1'b0;
    endtask

    task automatic test_random_stall();
        int diffs;
        run_stall(0);
        run_stall(1);
        diffs = 0;
        for (int k = 0; k < 32; k++) if (gaps[0][k] != gaps[1][k]) diffs++;
        n_checks++;
        if (diffs != 0) $display("FAIL stall_repeat: differing gaps=%0d required 0", diffs);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_order();
        test_round_robin();
        test_lock_clear();
        test_reset_midstream();
`ifdef BP_RESP_STREAM_RANDOM_STALL_EN
        test_random_stall();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
